// File: rtl/prod_shift_clip.sv
// prod_shift_clip: multi-flux actor that turns 18-bit product tokens into
// rounded, arithmetically right-shifted, 9-bit saturated results.
// Each block is announced by an ext_size token and a shift token, followed by
// ext_size*ext_size products. Up to FLUX interleaved streams share one
// datapath; each flux keeps its own state/cnt/size/shift context, and the
// lowest-numbered eligible flux fires each cycle with a combinational handshake.
// FIFO heads are presented side by side, flux i occupying slice i of each
// *_dout bus; tag bits in the token MSBs are carried but ignored on input.
module prod_shift_clip #(
  parameter int FLUX             = 2,
  parameter int TAG_WIDTH        = $clog2(FLUX),
  parameter int DATA_WIDTH_PROD  = 18,
  parameter int DATA_WIDTH_EXT   = 7,
  parameter int DATA_WIDTH_SHIFT = 4,
  parameter int DATA_WIDTH_OUT   = 9,
  parameter int DATA_WIDTH_CNT   = 2 * DATA_WIDTH_EXT
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [FLUX*(DATA_WIDTH_PROD+TAG_WIDTH)-1:0]   i_prod_dout,
  input  logic [FLUX-1:0]                               i_prod_empty,
  output logic [FLUX-1:0]                               o_prod_read,
  input  logic [FLUX*(DATA_WIDTH_EXT+TAG_WIDTH)-1:0]    i_ext_size_dout,
  input  logic [FLUX-1:0]                               i_ext_size_empty,
  output logic [FLUX-1:0]                               o_ext_size_read,
  input  logic [FLUX*(DATA_WIDTH_SHIFT+TAG_WIDTH)-1:0]  i_shift_dout,
  input  logic [FLUX-1:0]                               i_shift_empty,
  output logic [FLUX-1:0]                               o_shift_read,
  output logic [DATA_WIDTH_OUT+TAG_WIDTH-1:0]           o_res_din,
  input  logic [FLUX-1:0]                               i_res_full,
  output logic [FLUX-1:0]                               o_res_write
);

  localparam int PW = DATA_WIDTH_PROD + TAG_WIDTH;
  localparam int EW = DATA_WIDTH_EXT + TAG_WIDTH;
  localparam int SW = DATA_WIDTH_SHIFT + TAG_WIDTH;
  localparam int SAT_MAX_I = (1 << (DATA_WIDTH_OUT - 1)) - 1;
  localparam logic signed [DATA_WIDTH_PROD:0] SAT_MAX = (DATA_WIDTH_PROD + 1)'(SAT_MAX_I);
  localparam logic signed [DATA_WIDTH_PROD:0] SAT_MIN = (DATA_WIDTH_PROD + 1)'(-SAT_MAX_I - 1);
  localparam logic signed [DATA_WIDTH_PROD:0] RND_ONE = (DATA_WIDTH_PROD + 1)'(1);

  // Add half an LSB of the post-shift scale, then shift arithmetically.
  // One extra bit of headroom keeps the rounding bias from overflowing.
  function automatic logic signed [DATA_WIDTH_PROD:0] round_shift(
    input logic signed [DATA_WIDTH_PROD-1:0] p,
    input logic        [DATA_WIDTH_SHIFT-1:0] sh
  );
    logic signed [DATA_WIDTH_PROD:0] r;
    logic signed [DATA_WIDTH_PROD:0] bias;
    r    = {p[DATA_WIDTH_PROD-1], p};
    bias = '0;
    if (sh != '0) bias = RND_ONE << (sh - DATA_WIDTH_SHIFT'(1));
    r = r + bias;
    return r >>> sh;
  endfunction

  // Clamp to the signed output range.
  function automatic logic signed [DATA_WIDTH_OUT-1:0] saturate(
    input logic signed [DATA_WIDTH_PROD:0] s
  );
    if (s > SAT_MAX) return SAT_MAX[DATA_WIDTH_OUT-1:0];
    if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH_OUT-1:0];
    return s[DATA_WIDTH_OUT-1:0];
  endfunction

  // Per-flux context: state bit (0 = IDLE, 1 = WORK) and token counter are
  // control and reset; size and shift are data loaded at each block start.
  logic [FLUX-1:0]             r_state;
  logic [DATA_WIDTH_CNT-1:0]   r_cnt   [FLUX];
  logic [DATA_WIDTH_EXT-1:0]   r_size  [FLUX];
  logic [DATA_WIDTH_SHIFT-1:0] r_shift [FLUX];

  logic [FLUX-1:0]                    w_elig;
  logic                               w_fire;
  logic [TAG_WIDTH-1:0]               w_sel;
  logic                               w_idle_fire;
  logic                               w_work_fire;
  logic [DATA_WIDTH_EXT-1:0]          w_ext;
  logic [DATA_WIDTH_SHIFT-1:0]        w_shift_in;
  logic signed [DATA_WIDTH_PROD-1:0]  w_prod;
  logic [DATA_WIDTH_CNT-1:0]          w_size_ext;
  logic [DATA_WIDTH_CNT-1:0]          w_last;
  logic                               w_last_hit;
  logic signed [DATA_WIDTH_OUT-1:0]   w_res;

  // A flux may fire when its current state has everything it needs.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      w_elig[i] = r_state[i] ? (!i_prod_empty[i] && !i_res_full[i])
                             : (!i_ext_size_empty[i] && !i_shift_empty[i]);
    end
  end

  // Fixed priority: the lowest eligible index wins; nothing fires in reset.
  always_comb begin
    w_fire = 1'b0;
    w_sel  = '0;
    for (int i = FLUX - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_fire = 1'b1;
        w_sel  = TAG_WIDTH'(i);
      end
    end
    if (rst) w_fire = 1'b0;
  end

  assign w_idle_fire = w_fire && !r_state[w_sel];
  assign w_work_fire = w_fire &&  r_state[w_sel];

  assign w_ext      = i_ext_size_dout[w_sel*EW +: DATA_WIDTH_EXT];
  assign w_shift_in = i_shift_dout[w_sel*SW +: DATA_WIDTH_SHIFT];
  assign w_prod     = i_prod_dout[w_sel*PW +: DATA_WIDTH_PROD];

  // The counter is wide enough for 64*64 - 1, so the last index is exact.
  assign w_size_ext = {{(DATA_WIDTH_CNT - DATA_WIDTH_EXT){1'b0}}, r_size[w_sel]};
  assign w_last     = w_size_ext * w_size_ext - DATA_WIDTH_CNT'(1);
  assign w_last_hit = (r_cnt[w_sel] == w_last);

  assign w_res = saturate(round_shift(w_prod, r_shift[w_sel]));

  // Zero-latency handshake: only the winning flux's strobes are raised.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      o_ext_size_read[i] = w_idle_fire && (w_sel == TAG_WIDTH'(i));
      o_shift_read[i]    = w_idle_fire && (w_sel == TAG_WIDTH'(i));
      o_prod_read[i]     = w_work_fire && (w_sel == TAG_WIDTH'(i));
      o_res_write[i]     = w_work_fire && (w_sel == TAG_WIDTH'(i));
    end
    o_res_din = w_work_fire ? {w_sel, w_res} : '0;
  end

  // Control context: block start, per-product count, return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      for (int i = 0; i < FLUX; i++) r_cnt[i] <= '0;
    end else if (w_idle_fire) begin
      r_cnt[w_sel]   <= '0;
      r_state[w_sel] <= (w_ext != '0);
    end else if (w_work_fire) begin
      if (w_last_hit) begin
        r_cnt[w_sel]   <= '0;
        r_state[w_sel] <= 1'b0;
      end else begin
        r_cnt[w_sel] <= r_cnt[w_sel] + DATA_WIDTH_CNT'(1);
      end
    end
  end

  // Data context: capture block size and shift when a block starts.
  always_ff @(posedge clk) begin
    if (w_idle_fire) begin
      r_size[w_sel]  <= w_ext;
      r_shift[w_sel] <= w_shift_in;
    end
  end

endmodule

// File: tb/tb_prod_shift_clip.sv
// Bench for prod_shift_clip: queue-based FIFO models per flux feed the DUT,
// results are captured per flux and compared with a floor-division reference.
module tb_prod_shift_clip;

  localparam int FLUX = 2;
  localparam int TW = 1;
  localparam int DP = 18;
  localparam int DE = 7;
  localparam int DS = 4;
  localparam int DO = 9;
  localparam int PW = DP + TW;
  localparam int EW = DE + TW;
  localparam int SW = DS + TW;
  localparam int OW = DO + TW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [FLUX*PW-1:0] prod_dout = '0;
  logic [FLUX-1:0]    prod_empty = '1;
  logic [FLUX-1:0]    prod_read;
  logic [FLUX*EW-1:0] ext_dout = '0;
  logic [FLUX-1:0]    ext_empty = '1;
  logic [FLUX-1:0]    ext_read;
  logic [FLUX*SW-1:0] sh_dout = '0;
  logic [FLUX-1:0]    sh_empty = '1;
  logic [FLUX-1:0]    sh_read;
  logic [OW-1:0]      res_din;
  logic [FLUX-1:0]    res_full = '0;
  logic [FLUX-1:0]    res_write;

  prod_shift_clip #(.FLUX(FLUX)) dut (
    .clk(clk), .rst(rst),
    .i_prod_dout(prod_dout), .i_prod_empty(prod_empty), .o_prod_read(prod_read),
    .i_ext_size_dout(ext_dout), .i_ext_size_empty(ext_empty), .o_ext_size_read(ext_read),
    .i_shift_dout(sh_dout), .i_shift_empty(sh_empty), .o_shift_read(sh_read),
    .o_res_din(res_din), .i_res_full(res_full), .o_res_write(res_write)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int prod_q [FLUX][$];
  int ext_q  [FLUX][$];
  int sh_q   [FLUX][$];
  int exp_q  [FLUX][$];
  logic [OW-1:0] cap_q [FLUX][$];
  logic [OW-1:0] wr_log[$];
  int rd_cnt [FLUX];
  int multi_fire = 0;
  int hs_err = 0;
  int underflow = 0;
  logic [FLUX-1:0] last_pr, last_er, last_sr, last_rw;
  logic [OW-1:0] last_din;
  bit rand_full = 0;

  // Reference: round half up at the shifted scale, floor, clip to 9 bits.
  function automatic int ref_res(int p, int sh);
    int d, r, s;
    d = 1 << sh;
    r = p + d / 2;
    if (r >= 0) s = r / d;
    else        s = -((-r + d - 1) / d);
    if (s > 255)  s = 255;
    if (s < -256) s = -256;
    return s;
  endfunction

  function automatic logic [OW-1:0] enc(int f, int v);
    return {TW'(f), DO'(v)};
  endfunction

  task automatic refresh();
    for (int f = 0; f < FLUX; f++) begin
      prod_empty[f] = (prod_q[f].size() == 0);
      prod_dout[f*PW +: PW] = prod_empty[f] ? '0 : {TW'(f ^ 1), DP'(prod_q[f][0])};
      ext_empty[f] = (ext_q[f].size() == 0);
      ext_dout[f*EW +: EW] = ext_empty[f] ? '0 : {TW'(f ^ 1), DE'(ext_q[f][0])};
      sh_empty[f] = (sh_q[f].size() == 0);
      sh_dout[f*SW +: SW] = sh_empty[f] ? '0 : {TW'(f ^ 1), DS'(sh_q[f][0])};
      if (rand_full) res_full[f] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    last_pr = prod_read;
    last_er = ext_read;
    last_sr = sh_read;
    last_rw = res_write;
    last_din = res_din;
    if ($countones(last_pr | last_er | last_sr | last_rw) > 1) multi_fire++;
    if (last_er != last_sr || last_pr != last_rw) hs_err++;
    for (int f = 0; f < FLUX; f++) begin
      if (last_rw[f]) begin
        cap_q[f].push_back(last_din);
        wr_log.push_back(last_din);
      end
    end
    @(posedge clk);
    #1;
    for (int f = 0; f < FLUX; f++) begin
      if (last_pr[f]) begin
        if (prod_q[f].size() > 0) prod_q[f].delete(0); else underflow++;
        rd_cnt[f]++;
      end
      if (last_er[f]) begin
        if (ext_q[f].size() > 0) ext_q[f].delete(0); else underflow++;
      end
      if (last_sr[f]) begin
        if (sh_q[f].size() > 0) sh_q[f].delete(0); else underflow++;
      end
    end
    refresh();
  endtask

  task automatic clear_fifos();
    for (int f = 0; f < FLUX; f++) begin
      prod_q[f].delete();
      ext_q[f].delete();
      sh_q[f].delete();
      exp_q[f].delete();
      cap_q[f].delete();
      rd_cnt[f] = 0;
    end
    wr_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    res_full = '0;
    clear_fifos();
    refresh();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_results(int budget);
    int b = 0;
    while ((cap_q[0].size() < exp_q[0].size() || cap_q[1].size() < exp_q[1].size())
           && b < budget) begin
      tick();
      b++;
    end
    repeat (3) tick();
  endtask

  task automatic push_ctrl(int f, int size, int sh);
    ext_q[f].push_back(size);
    sh_q[f].push_back(sh);
  endtask

  task automatic push_prod(int f, int p, int sh, bit expect_out);
    prod_q[f].push_back(p);
    if (expect_out) exp_q[f].push_back(ref_res(p, sh));
  endtask

  task automatic push_rand_block(int f, int size, int sh, int lo, int hi);
    push_ctrl(f, size, sh);
    repeat (size * size) push_prod(f, int'($urandom_range(0, hi - lo)) + lo, sh, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_fifos();
    push_ctrl(0, 1, 0); push_prod(0, 7, 0, 1'b0);
    push_ctrl(1, 1, 0); push_prod(1, 7, 0, 1'b0);
    refresh();
    tick();
    n_checks++;
    if ((last_pr | last_er | last_sr | last_rw) !== '0) begin
      n_errors++;
      $display("FAIL reset_strobes: got pr=%b er=%b sr=%b wr=%b want all 0",
               last_pr, last_er, last_sr, last_rw);
    end
    n_checks++;
    if (last_din !== '0) begin
      n_errors++;
      $display("FAIL reset_din: got %h want 0", last_din);
    end
    tick();
    rst = 1'b0;
    clear_fifos();
    push_prod(0, 9, 0, 1'b0);
    refresh();
    repeat (4) tick();
    n_checks++;
    if (rd_cnt[0] != 0 || cap_q[0].size() != 0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got reads=%0d writes=%0d want 0 0",
               rd_cnt[0], cap_q[0].size());
    end
    do_reset();
  endtask

  task automatic test_single_block();
    int want [4] = '{1, -1, 2, 250};
    push_ctrl(0, 2, 2);
    push_prod(0, 5, 2, 1'b0);
    push_prod(0, -5, 2, 1'b0);
    push_prod(0, 6, 2, 1'b0);
    push_prod(0, 1000, 2, 1'b0);
    push_prod(0, 77, 2, 1'b0);
    refresh();
    repeat (10) tick();
    n_checks++;
    if (cap_q[0].size() != 4) begin
      n_errors++;
      $display("FAIL single_count: got %0d want 4", cap_q[0].size());
    end
    for (int k = 0; k < 4; k++) begin
      logic [OW-1:0] g;
      g = (k < cap_q[0].size()) ? cap_q[0][k] : 'x;
      n_checks++;
      if (g !== enc(0, want[k])) begin
        n_errors++;
        $display("FAIL single_res[%0d]: got %h want %h", k, g, enc(0, want[k]));
      end
    end
    n_checks++;
    if (prod_q[0].size() != 1) begin
      n_errors++;
      $display("FAIL single_fifth_unread: got %0d left want 1", prod_q[0].size());
    end
    do_reset();
  endtask

  task automatic test_saturation();
    int want [3] = '{255, -256, 4};
    push_ctrl(0, 1, 0);  push_prod(0, 300, 0, 1'b0);
    push_ctrl(0, 1, 0);  push_prod(0, -300, 0, 1'b0);
    push_ctrl(0, 1, 15); push_prod(0, 131071, 15, 1'b0);
    refresh();
    repeat (12) tick();
    n_checks++;
    if (cap_q[0].size() != 3) begin
      n_errors++;
      $display("FAIL sat_count: got %0d want 3", cap_q[0].size());
    end
    for (int k = 0; k < 3; k++) begin
      logic [OW-1:0] g;
      g = (k < cap_q[0].size()) ? cap_q[0][k] : 'x;
      n_checks++;
      if (g !== enc(0, want[k])) begin
        n_errors++;
        $display("FAIL sat_res[%0d]: got %h want %h", k, g, enc(0, want[k]));
      end
    end
    do_reset();
  endtask

  task automatic test_zero_size();
    push_ctrl(0, 0, 5);
    push_ctrl(0, 1, 1);
    push_prod(0, 3, 1, 1'b0);
    refresh();
    tick();
    n_checks++;
    if (last_er[0] !== 1'b1 || last_pr !== '0) begin
      n_errors++;
      $display("FAIL zero_size_pop: got er=%b pr=%b want er0=1 pr=00", last_er, last_pr);
    end
    tick();
    n_checks++;
    if (last_er[0] !== 1'b1 || last_pr !== '0) begin
      n_errors++;
      $display("FAIL zero_size_next_ctrl: got er=%b pr=%b want er0=1 pr=00", last_er, last_pr);
    end
    repeat (4) tick();
    n_checks++;
    if (cap_q[0].size() != 1 || cap_q[0][0] !== enc(0, 2)) begin
      n_errors++;
      $display("FAIL zero_size_result: got n=%0d first=%h want n=1 %h",
               cap_q[0].size(), (cap_q[0].size() > 0) ? cap_q[0][0] : '0, enc(0, 2));
    end
    do_reset();
  endtask

  task automatic test_arbitration();
    int bad;
    int mf0;
    mf0 = multi_fire;
    push_rand_block(0, 2, 0, -400, 400);
    push_rand_block(1, 2, 0, -400, 400);
    refresh();
    wait_results(40);
    n_checks++;
    if (wr_log.size() != 8) begin
      n_errors++;
      $display("FAIL arb_count: got %0d want 8", wr_log.size());
    end
    bad = 0;
    for (int k = 0; k < wr_log.size(); k++) begin
      if (int'(wr_log[k][OW-1]) != ((k < 4) ? 0 : 1)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL arb_order: got %0d out-of-order tags want 0", bad);
    end
    for (int f = 0; f < FLUX; f++) begin
      bad = 0;
      for (int k = 0; k < exp_q[f].size(); k++) begin
        if (k >= cap_q[f].size() || cap_q[f][k] !== enc(f, exp_q[f][k])) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_errors++;
        $display("FAIL arb_values_f%0d: got %0d wrong want 0", f, bad);
      end
    end
    n_checks++;
    if (multi_fire != mf0) begin
      n_errors++;
      $display("FAIL arb_single_fire: got %0d multi-flux cycles want 0", multi_fire - mf0);
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int b, c0, c1, viol, bad;
    push_rand_block(0, 2, 0, -300, 300);
    push_rand_block(1, 2, 0, -300, 300);
    refresh();
    b = 0;
    while (cap_q[0].size() < 1 && b < 10) begin
      tick();
      b++;
    end
    res_full[0] = 1'b1;
    c0 = cap_q[0].size();
    c1 = cap_q[1].size();
    viol = 0;
    repeat (5) begin
      tick();
      if (last_pr[0] || last_rw[0]) viol++;
    end
    n_checks++;
    if (viol != 0 || cap_q[0].size() != c0 || c0 != 1) begin
      n_errors++;
      $display("FAIL bp_stall_f0: got viol=%0d writes=%0d want viol=0 writes=1",
               viol, cap_q[0].size());
    end
    n_checks++;
    if (cap_q[1].size() != 4 || c1 != 0) begin
      n_errors++;
      $display("FAIL bp_f1_progress: got %0d results want 4", cap_q[1].size());
    end
    res_full[0] = 1'b0;
    wait_results(20);
    bad = 0;
    for (int k = 0; k < exp_q[0].size(); k++) begin
      if (k >= cap_q[0].size() || cap_q[0][k] !== enc(0, exp_q[0][k])) bad++;
    end
    n_checks++;
    if (bad != 0 || cap_q[0].size() != 4) begin
      n_errors++;
      $display("FAIL bp_resume_f0: got n=%0d wrong=%0d want n=4 wrong=0",
               cap_q[0].size(), bad);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int b, bad;
    push_ctrl(0, 4, 0);
    repeat (16) push_prod(0, int'($urandom_range(0, 1000)), 0, 1'b0);
    refresh();
    b = 0;
    while (rd_cnt[0] < 7 && b < 30) begin
      tick();
      b++;
    end
    n_checks++;
    if (rd_cnt[0] != 7) begin
      n_errors++;
      $display("FAIL rstmid_reach7: got %0d reads want 7", rd_cnt[0]);
    end
    rst = 1'b1;
    clear_fifos();
    refresh();
    tick();
    rst = 1'b0;
    push_rand_block(0, 4, 1, -2000, 2000);
    push_prod(0, 55, 1, 1'b0);
    refresh();
    wait_results(40);
    bad = 0;
    for (int k = 0; k < exp_q[0].size(); k++) begin
      if (k >= cap_q[0].size() || cap_q[0][k] !== enc(0, exp_q[0][k])) bad++;
    end
    n_checks++;
    if (bad != 0 || cap_q[0].size() != 16) begin
      n_errors++;
      $display("FAIL rstmid_fresh_block: got n=%0d wrong=%0d want n=16 wrong=0",
               cap_q[0].size(), bad);
    end
    n_checks++;
    if (prod_q[0].size() != 1) begin
      n_errors++;
      $display("FAIL rstmid_extra_unread: got %0d left want 1", prod_q[0].size());
    end
    do_reset();
  endtask

  task automatic test_size64();
    int bad, first;
    push_rand_block(1, 64, int'($urandom_range(1, 15)), -131072, 131071);
    push_prod(1, 123, 0, 1'b0);
    refresh();
    wait_results(4300);
    n_checks++;
    if (cap_q[1].size() != 4096) begin
      n_errors++;
      $display("FAIL s64_count: got %0d want 4096", cap_q[1].size());
    end
    bad = 0;
    first = -1;
    for (int k = 0; k < exp_q[1].size(); k++) begin
      if (k >= cap_q[1].size() || cap_q[1][k] !== enc(1, exp_q[1][k])) begin
        if (first < 0) first = k;
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL s64_values: got %0d wrong (first idx %0d) want 0", bad, first);
    end
    n_checks++;
    if (prod_q[1].size() != 1) begin
      n_errors++;
      $display("FAIL s64_extra_unread: got %0d left want 1", prod_q[1].size());
    end
    do_reset();
  endtask

  task automatic test_random();
    int bad;
    rand_full = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int f = 0; f < FLUX; f++) begin
        push_rand_block(f, int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
                        -131072, 131071);
      end
    end
    refresh();
    wait_results(2000);
    rand_full = 1'b0;
    res_full = '0;
    refresh();
    wait_results(200);
    for (int f = 0; f < FLUX; f++) begin
      bad = 0;
      for (int k = 0; k < exp_q[f].size(); k++) begin
        if (k >= cap_q[f].size() || cap_q[f][k] !== enc(f, exp_q[f][k])) bad++;
      end
      n_checks++;
      if (bad != 0 || cap_q[f].size() != exp_q[f].size()) begin
        n_errors++;
        $display("FAIL rand_f%0d: got n=%0d wrong=%0d want n=%0d wrong=0",
                 f, cap_q[f].size(), bad, exp_q[f].size());
      end
    end
    n_checks++;
    if (multi_fire != 0 || hs_err != 0 || underflow != 0) begin
      n_errors++;
      $display("FAIL handshake_rules: got multi=%0d hs=%0d underflow=%0d want 0 0 0",
               multi_fire, hs_err, underflow);
    end
    do_reset();
  endtask

  initial begin
    refresh();
    test_reset();
    test_single_block();
    test_saturation();
    test_zero_size();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_size64();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
